// File: rtl/pwm_decoder_pkg.sv
// Shared constants, FSM state type and helpers for the PWM link receive side.
package pwm_decoder_pkg;

  localparam int unsigned PWM_PERIOD         = 2500;
  localparam int unsigned PWM_TICKS_PER_STEP = 10;
  localparam int unsigned PWM_MAX_DUTY       = 250;
  localparam int unsigned PWM_TOL            = 25;

  localparam int unsigned CNT_W = 12;

  localparam logic [CNT_W-1:0] CNT_MIN    = CNT_W'(PWM_PERIOD - PWM_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PWM_PERIOD + PWM_TOL);
  localparam logic [3:0]       PRESC_LOAD = 4'(PWM_TICKS_PER_STEP / 2);
  localparam logic [3:0]       PRESC_WRAP = 4'(PWM_TICKS_PER_STEP - 1);
  localparam logic [7:0]       DUTY_MAX   = 8'(PWM_MAX_DUTY);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_state_e;

  function automatic logic [7:0] clamp_duty(input logic [7:0] step);
    return (step > DUTY_MAX) ? DUTY_MAX : step;
  endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// PWM line input and recovered duty/status outputs of the decoder.
interface pwm_decoder_if;
  logic       PWM_in;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       period_err;
  logic       signal_lost;

  modport master (output PWM_in, input duty_out, duty_valid, period_err, signal_lost);
  modport slave  (input PWM_in, output duty_out, duty_valid, period_err, signal_lost);
endinterface

// File: rtl/pwm_decoder_edge_sync.sv
// Two-flop synchronizer plus edge register; rise/fall strobes and level are
// mutually aligned, so pulse widths survive the crossing unchanged.
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, level_q, rise_q, fall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      rise_q  <= sync2_q & ~level_q;
      fall_q  <= ~sync2_q & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM link receiver: measures period and high time of the incoming line and
// recovers the duty code, flagging bad periods and a stuck line.
module pwm_decoder
  import pwm_decoder_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  pwm_decoder_if.slave bus
);

  logic level, rise, fall;

  edge_sync u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.PWM_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [3:0]       presc_q, presc_d;
  logic [7:0]       step_q, step_d;
  logic [7:0]       duty_q, duty_d;
  logic             valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic             accept_rise, complete, timeout, in_window;

  // A rise at the timeout threshold is a completion, so it pre-empts the timeout.
  always_comb begin
    accept_rise = rise && (state_q != HIGH);
    complete    = rise && (state_q == LOW);
    timeout     = (period_cnt_q == CNT_MAX) && !accept_rise;
    in_window   = (period_cnt_q >= CNT_MIN) && (period_cnt_q <= CNT_MAX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= WAIT_RISE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = level ? HIGH : LOW;
    end else begin
      unique case (state_q)
        WAIT_RISE: if (rise) state_d = HIGH;
        HIGH:      if (fall) state_d = LOW;
        LOW:       if (rise) state_d = HIGH;
        default:   state_d = WAIT_RISE;
      endcase
    end
  end

  always_comb begin
    period_cnt_d = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 1'b1;
    presc_d      = presc_q;
    step_d       = step_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    lost_d       = lost_q;

    if (state_q == HIGH) begin
      if (presc_q == PRESC_WRAP) begin
        presc_d = '0;
        if (step_q != '1) step_d = step_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // A timeout restarts the measurement exactly like a synthetic rise.
    if (accept_rise || timeout) begin
      period_cnt_d = CNT_W'(1);
      presc_d      = PRESC_LOAD;
      step_d       = '0;
    end

    if (complete) begin
      if (in_window) begin
        duty_d  = clamp_duty(step_q);
        valid_d = 1'b1;
        err_d   = 1'b0;
        lost_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (timeout) begin
      duty_d  = level ? DUTY_MAX : '0;
      valid_d = 1'b1;
      lost_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_cnt_q <= '0;
      presc_q      <= '0;
      step_q       <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
    end
  end

  assign bus.duty_out    = duty_q;
  assign bus.duty_valid  = valid_q;
  assign bus.period_err  = err_q;
  assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: directed period table, stuck-line and reset sequences,
// and random periods, all shadowed cycle by cycle by an event-level reference model.
module tb_pwm_decoder;

  typedef struct {
    int unsigned high;
    int unsigned period;
    int unsigned duty;
    bit          err;
    int unsigned valids;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pwm_decoder_if bus_if ();

  pwm_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit in_reset = 1'b0;

  // reference model: pin history plus times of the last anchor and high start
  bit pin_ring [8];
  int m_rel    = 0;
  int m_anchor = 1;
  int m_hstart = 0;
  int m_step   = 0;
  bit m_armed  = 1'b0;
  bit m_high   = 1'b0;
  int exp_duty = 0;
  bit exp_valid = 1'b0, exp_err = 1'b0, exp_lost = 1'b0;

  int valid_cnt = 0, last_v = 0, prev_v = 0;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      if (errors >= 20) finish_run();
    end
  endtask

  function automatic bit pin_at(input int c);
    if (c < 0 || c < m_rel) return 1'b0;
    return pin_ring[c % 8];
  endfunction

  // Line level seen by the decoder at edge e is the pin 4 cycles earlier.
  task automatic model_edge(input int e);
    bit lvl, prv, r, f;
    int p, s;
    lvl = pin_at(e - 4);
    prv = pin_at(e - 5);
    r = lvl & ~prv;
    f = ~lvl & prv;
    p = e - m_anchor;
    exp_valid = 1'b0;
    if (r && (!m_armed || !m_high)) begin
      if (m_armed) begin
        if (p >= 2475 && p <= 2525) begin
          exp_duty  = (m_step > 250) ? 250 : m_step;
          exp_valid = 1'b1;
          exp_err   = 1'b0;
          exp_lost  = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
      m_armed = 1'b1; m_high = 1'b1; m_anchor = e; m_hstart = e;
    end else if (p == 2525) begin
      exp_duty  = lvl ? 250 : 0;
      exp_valid = 1'b1;
      exp_lost  = 1'b1;
      m_armed = 1'b1; m_high = lvl; m_anchor = e; m_hstart = e; m_step = 0;
    end else if (m_armed && m_high && f) begin
      m_high = 1'b0;
      s = (e - m_hstart + 5) / 10;
      m_step = (s > 255) ? 255 : s;
    end
  endtask

  task automatic tick(input bit pin_v);
    int act, exp;
    @(posedge clock);
    cyc++;
    #1;
    if (in_reset) begin
      exp_duty = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_lost = 1'b0;
    end else begin
      model_edge(cyc);
    end
    if (bus_if.duty_valid) begin
      valid_cnt++;
      prev_v = last_v;
      last_v = cyc;
    end
    act = int'(bus_if.duty_out) * 8 + int'(bus_if.duty_valid) * 4
        + int'(bus_if.period_err) * 2 + int'(bus_if.signal_lost);
    exp = exp_duty * 8 + int'(exp_valid) * 4 + int'(exp_err) * 2 + int'(exp_lost);
    check("model duty*8+valid*4+err*2+lost", act, exp);
    bus_if.PWM_in = pin_v;
    pin_ring[cyc % 8] = pin_v;
  endtask

  task automatic hold_reset(input int n, input bit pin_v);
    reset = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_reset_duty", int'(bus_if.duty_out), 0);
    check("async_reset_flags",
          int'({bus_if.duty_valid, bus_if.period_err, bus_if.signal_lost}), 0);
    repeat (n) tick(pin_v);
    reset = 1'b1;
    in_reset = 1'b0;
    m_rel = cyc; m_anchor = cyc + 1;
    m_armed = 1'b0; m_high = 1'b0; m_step = 0;
  endtask

  task automatic drive_span(input int unsigned h, input int unsigned from, input int unsigned to);
    for (int unsigned c = from; c < to; c++) tick(c < h);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    check($sformatf("vec%0d_duty", idx), int'(bus_if.duty_out), int'(v.duty));
    check($sformatf("vec%0d_err", idx), int'(bus_if.period_err), int'(v.err));
    check($sformatf("vec%0d_lost", idx), int'(bus_if.signal_lost), 0);
    check($sformatf("vec%0d_valids", idx), valid_cnt, int'(v.valids));
    valid_cnt = 0;
  endtask

  initial begin
    vec_t tbl [12];
    tbl = '{
      '{1000, 2500, 100, 1'b0, 1},
      '{  10, 2500,   1, 1'b0, 1},
      '{  14, 2500,   1, 1'b0, 1},
      '{  15, 2500,   2, 1'b0, 1},
      '{2490, 2500, 249, 1'b0, 1},
      '{   1, 2500,   0, 1'b0, 1},
      '{ 500, 2475,  50, 1'b0, 1},
      '{ 700, 2525,  70, 1'b0, 1},
      '{1000, 2500, 100, 1'b0, 1},
      '{ 500, 2000, 100, 1'b1, 0},
      '{ 400, 2500,  40, 1'b0, 1},
      '{ 600, 2474,  40, 1'b1, 0}
    };

    bus_if.PWM_in = 1'b0;
    hold_reset(4, 1'b0);
    repeat (3) tick(1'b0);

    // each vector's completion is checked 6 cycles into the following period
    for (int i = 0; i < 12; i++) begin
      drive_span(tbl[i].high, 0, 6);
      if (i > 0) check_vec(tbl[i-1], i - 1);
      drive_span(tbl[i].high, 6, tbl[i].period);
    end

    // line stuck high for 6000 clocks
    drive_span(6000, 0, 6);
    check_vec(tbl[11], 11);
    drive_span(6000, 6, 6000);
    check("stuck_high_valids", valid_cnt, 2);
    check("stuck_high_duty", int'(bus_if.duty_out), 250);
    check("stuck_high_lost", int'(bus_if.signal_lost), 1);
    check("stuck_high_interval", last_v - prev_v, 2525);
    valid_cnt = 0;
    drive_span(0, 0, 1000);
    drive_span(500, 0, 6);
    check("after_stuck_short_err", int'(bus_if.period_err), 1);
    check("after_stuck_short_lost", int'(bus_if.signal_lost), 1);
    check("after_stuck_short_duty", int'(bus_if.duty_out), 250);
    check("after_stuck_short_valids", valid_cnt, 0);
    drive_span(500, 6, 2500);

    // normal period clears the stuck flag, then the line stays low
    drive_span(1000, 0, 6);
    check("recover_duty", int'(bus_if.duty_out), 50);
    check("recover_lost", int'(bus_if.signal_lost), 0);
    check("recover_err", int'(bus_if.period_err), 0);
    check("recover_valids", valid_cnt, 1);
    valid_cnt = 0;
    drive_span(1000, 6, 2500);
    drive_span(0, 0, 3000);
    check("stuck_low_valids", valid_cnt, 2);
    check("stuck_low_duty", int'(bus_if.duty_out), 0);
    check("stuck_low_lost", int'(bus_if.signal_lost), 1);
    check("stuck_low_interval", last_v - prev_v, 2525);

    // reset in the middle of a high phase
    drive_span(1000, 0, 2500);
    drive_span(1000, 0, 2500);
    drive_span(1000, 0, 300);
    check("pre_reset_duty", int'(bus_if.duty_out), 100);
    valid_cnt = 0;
    hold_reset(3, 1'b1);
    drive_span(1000, 303, 2500);
    drive_span(1000, 0, 6);
    check("post_reset_first_rise_valids", valid_cnt, 0);
    check("post_reset_first_rise_duty", int'(bus_if.duty_out), 0);
    drive_span(1000, 6, 2500);
    drive_span(1000, 0, 6);
    check("post_reset_second_rise_valids", valid_cnt, 1);
    check("post_reset_second_rise_duty", int'(bus_if.duty_out), 100);
    drive_span(1000, 6, 2500);

    // random periods, including short and over-long ones
    for (int k = 0; k < 6; k++) begin
      int unsigned p, h, sel;
      sel = $urandom_range(0, 3);
      if (sel < 2)       p = $urandom_range(2475, 2525);
      else if (sel == 2) p = $urandom_range(1500, 2474);
      else               p = $urandom_range(2526, 2900);
      h = $urandom_range(1, p - 1);
      drive_span(h, 0, p);
    end
    drive_span(100, 0, 20);

    finish_run();
  end

endmodule
